// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: grant, valid/ready handshake,
// fixed-length transfer window, then a one-cycle release/turnaround.
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_LEN    = 12,
    parameter int DATA_LEN    = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [NUM_MASTERS-1:0]         m_valid,
    input  logic                           slave_ready,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           bus_valid,
    output logic                           bus_busy,
    output logic                           timeout_err
);
    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int WW  = $clog2(TIMEOUT + 1);
    localparam int XW  = $clog2(ADDR_LEN + 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic [1:0] {IDLE, GRANTED, TRANSFER, RELEASE} state_t;

    // Data shifts alongside address, so the window must cover both.
    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
            $error("bus_arbiter: NUM_MASTERS must be 2..8");
        end
        if (DATA_LEN < 1 || DATA_LEN > ADDR_LEN) begin : g_bad_data_len
            $error("bus_arbiter: DATA_LEN must be 1..ADDR_LEN");
        end
    endgenerate

    state_t                  state, state_n;
    logic [NUM_MASTERS-1:0]  grant_n;
    logic [IDW-1:0]          gid_n;
    logic [IDW-1:0]          last_grant, last_n;
    logic [WW-1:0]           wait_cnt, wait_n;
    logic [XW-1:0]           xfer_cnt, xfer_n;
    logic                    terr_n;
    logic [IDW-1:0]          cand;
    logic [IDW-1:0]          pick_id;
    logic                    pick_vld;
    logic                    handshake;

    assign bus_valid = (state == GRANTED) && |(m_valid & grant);
    assign bus_busy  = (state != IDLE);
    assign handshake = bus_valid & slave_ready;

    // Scan upward from the master after the last owner, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDW'((int'(last_grant) + i) % NUM_MASTERS);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        gid_n   = grant_id;
        last_n  = last_grant;
        wait_n  = wait_cnt;
        xfer_n  = xfer_cnt;
        terr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_n = ONE_HOT0 << pick_id;
                    gid_n   = pick_id;
                    wait_n  = '0;
                    state_n = GRANTED;
                end
            end
            GRANTED: begin
                // Handshake has priority over a coincident timeout.
                if (handshake) begin
                    xfer_n  = XW'(ADDR_LEN);
                    state_n = TRANSFER;
                end else if (!req[grant_id]) begin
                    grant_n = '0;
                    state_n = RELEASE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    terr_n  = 1'b1;
                    grant_n = '0;
                    state_n = RELEASE;
                end else begin
                    wait_n  = wait_cnt + 1'b1;
                end
            end
            TRANSFER: begin
                xfer_n = xfer_cnt - 1'b1;
                if (xfer_cnt == XW'(1)) begin
                    grant_n = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                last_n  = grant_id;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            last_grant  <= IDW'(NUM_MASTERS - 1);
            wait_cnt    <= '0;
            xfer_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_id    <= gid_n;
            last_grant  <= last_n;
            wait_cnt    <= wait_n;
            xfer_cnt    <= xfer_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int N   = 2;
    localparam int AL  = 12;
    localparam int TO  = 64;
    localparam int P_IDLE = 0, P_GR = 1, P_XF = 2, P_REL = 3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N-1:0]           req = '0;
    logic [N-1:0]           m_valid = '0;
    logic                   slave_ready = 1'b0;
    logic [N-1:0]           grant;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   bus_valid;
    logic                   bus_busy;
    logic                   timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.NUM_MASTERS(N), .ADDR_LEN(AL), .DATA_LEN(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .m_valid(m_valid),
        .slave_ready(slave_ready), .grant(grant), .grant_id(grant_id),
        .bus_valid(bus_valid), .bus_busy(bus_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mv;
        logic         sr;
        logic [N-1:0] eg;
        logic         ev;
        logic         eb;
        logic         et;
    } vec_t;
    vec_t tbl[$];

    function automatic void push(input logic [N-1:0] r, input logic [N-1:0] mv, input logic sr,
                                 input logic [N-1:0] eg, input logic ev, input logic eb, input logic et);
        vec_t v;
        v.req = r; v.mv = mv; v.sr = sr; v.eg = eg; v.ev = ev; v.eb = eb; v.et = et;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; m_valid = '0; slave_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: owner / phase / remaining-cycle bookkeeping.
    int   mph, owner, age, left_cyc, last, e_gid;
    logic e_terr;

    function automatic void mdl_reset();
        mph = P_IDLE; owner = 0; age = 0; left_cyc = 0; last = N - 1; e_gid = 0; e_terr = 1'b0;
    endfunction

    function automatic void mdl_step(input logic [N-1:0] r, input logic [N-1:0] mv, input logic sr);
        bit found;
        e_terr = 1'b0;
        case (mph)
            P_IDLE: begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int m;
                    m = (last + k) % N;
                    if (!found && r[m]) begin
                        found = 1; owner = m;
                    end
                end
                if (found) begin
                    mph = P_GR; age = 0; e_gid = owner;
                end
            end
            P_GR: begin
                if (mv[owner] && sr) begin
                    mph = P_XF; left_cyc = AL;
                end else if (!r[owner]) begin
                    mph = P_REL;
                end else if (age == TO - 1) begin
                    mph = P_REL; e_terr = 1'b1;
                end else begin
                    age++;
                end
            end
            P_XF: begin
                left_cyc--;
                if (left_cyc == 0) mph = P_REL;
            end
            default: begin
                last = owner; mph = P_IDLE;
            end
        endcase
    endfunction

    function automatic logic [31:0] mdl_grant();
        return (mph == P_GR || mph == P_XF) ? (32'd1 << owner) : 32'd0;
    endfunction

    initial begin
        // Master 0 fresh, then a round trip through master 1 with masking.
        push(2'b01, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        push(2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 12; k++)
            push((k % 2) ? 2'b11 : 2'b00, (k % 3 == 0) ? 2'b00 : 2'b11, k[0],
                 2'b01, 1'b0, 1'b1, 1'b0);
        push(2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        push(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        push(2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        push(2'b11, 2'b11, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
        push(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        push(2'b11, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        push(2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);

        #1 reset = 1'b1;
        #2;
        chk("reset grant",    32'(grant), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset busy",     32'(bus_busy), 32'd0);
        chk("reset valid",    32'(bus_valid), 32'd0);
        chk("reset terr",     32'(timeout_err), 32'd0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req; m_valid = tbl[i].mv; slave_ready = tbl[i].sr;
            #1 chk($sformatf("tbl[%0d] bus_valid", i), 32'(bus_valid), 32'(tbl[i].ev));
            @(posedge clk); #1;
            chk($sformatf("tbl[%0d] grant", i), 32'(grant), 32'(tbl[i].eg));
            chk($sformatf("tbl[%0d] busy", i), 32'(bus_busy), 32'(tbl[i].eb));
            chk($sformatf("tbl[%0d] terr", i), 32'(timeout_err), 32'(tbl[i].et));
            @(negedge clk);
        end
        chk("tbl grant_id", 32'(grant_id), 32'd1);

        // Now in TRANSFER cycle 1 for master 1; reset asynchronously in cycle 5.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("xfer5 grant", 32'(grant), 32'h2);
        req = 2'b11; m_valid = 2'b11; reset = 1'b1;
        #1;
        chk("midreset grant", 32'(grant), 32'd0);
        chk("midreset busy",  32'(bus_busy), 32'd0);
        chk("midreset valid", 32'(bus_valid), 32'd0);
        chk("midreset gid",   32'(grant_id), 32'd0);
        @(negedge clk);
        reset = 1'b0; slave_ready = 1'b0;
        @(posedge clk); #1;
        chk("post-reset first grant", 32'(grant), 32'h1);

        // Continuous contention: 13-cycle grants, RELEASE + IDLE gap.
        do_reset();
        req = 2'b11; m_valid = 2'b11; slave_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int pos;
            logic [31:0] eg;
            @(posedge clk); #1;
            pos = k % 15;
            eg  = (pos < 13) ? (((k / 15) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0;
            chk($sformatf("alt[%0d] grant", k), 32'(grant), eg);
            chk($sformatf("alt[%0d] busy", k), 32'(bus_busy), (pos != 14) ? 32'd1 : 32'd0);
        end

        // Timeout on master 1 with master 0 waiting.
        do_reset();
        req = 2'b10; m_valid = 2'b00; slave_ready = 1'b1;
        @(posedge clk); #1;
        chk("to grant0", 32'(grant), 32'h2);
        @(negedge clk);
        req = 2'b11;
        for (int i = 1; i < TO; i++) begin
            @(posedge clk); #1;
            chk($sformatf("to wait[%0d]", i), {30'd0, grant} | (32'(timeout_err) << 4), 32'h2);
        end
        @(posedge clk); #1;
        chk("to drop grant", 32'(grant), 32'd0);
        chk("to pulse",      32'(timeout_err), 32'd1);
        @(posedge clk); #1;
        chk("to pulse end",  32'(timeout_err), 32'd0);
        chk("to idle",       32'(bus_busy), 32'd0);
        @(posedge clk); #1;
        chk("to next grant", 32'(grant), 32'h1);

        // Master 0 abandons its grant before asserting valid.
        do_reset();
        req = 2'b01; m_valid = 2'b00; slave_ready = 1'b1;
        @(posedge clk); #1;
        chk("ab grant", 32'(grant), 32'h1);
        @(negedge clk); req = 2'b11;
        @(posedge clk); #1;
        chk("ab hold", 32'(grant), 32'h1);
        @(negedge clk); req = 2'b10;
        #1 chk("ab valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        chk("ab release grant", 32'(grant), 32'd0);
        chk("ab release busy",  32'(bus_busy), 32'd1);
        chk("ab no terr",       32'(timeout_err), 32'd0);
        @(negedge clk); req = 2'b11;
        @(posedge clk); #1;
        chk("ab idle", 32'(bus_busy), 32'd0);
        @(posedge clk); #1;
        chk("ab next grant", 32'(grant), 32'h2);

        // Randomized run against the reference model.
        do_reset();
        mdl_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            m_valid     = N'($urandom);
            slave_ready = ($urandom_range(3) == 0);
            #1 chk("rnd bus_valid", 32'(bus_valid),
                   (mph == P_GR && m_valid[owner]) ? 32'd1 : 32'd0);
            @(posedge clk);
            mdl_step(req, m_valid, slave_ready);
            #1;
            chk("rnd grant",    32'(grant), mdl_grant());
            chk("rnd busy",     32'(bus_busy), (mph != P_IDLE) ? 32'd1 : 32'd0);
            chk("rnd terr",     32'(timeout_err), 32'(e_terr));
            chk("rnd grant_id", 32'(grant_id), 32'(e_gid));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
